// File: rtl/pc_fetch_unit_pkg.sv
// Shared types for the PC fetch unit: FSM encoding, reset PC default and the
// instruction/PC packet held by the output register.
package pc_fetch_unit_pkg;
   localparam int          INST_W       = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2,
      S_ERROR   = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [31:0]       pc;
   } fetch_pkt_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of PC adder, instruction-memory and decode-side signals of the fetch unit.
// master = fetch unit, slave = surrounding pipeline / memory.
interface pc_fetch_unit_if;
   import pc_fetch_unit_pkg::*;

   logic [31:0]       newAddress;
   logic [31:0]       currentAddress;
   logic              redirect;
   logic [31:0]       redirect_addr;
   logic              imem_req;
   logic [31:0]       imem_addr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_rdata;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] instruction;
   logic [31:0]       inst_pc;
   logic              fetch_err;

   modport master (
      input  newAddress, redirect, redirect_addr, imem_ack, imem_rdata, inst_ready,
      output currentAddress, imem_req, imem_addr, inst_valid, instruction, inst_pc, fetch_err
   );

   modport slave (
      output newAddress, redirect, redirect_addr, imem_ack, imem_rdata, inst_ready,
      input  currentAddress, imem_req, imem_addr, inst_valid, instruction, inst_pc, fetch_err
   );
endinterface

// File: rtl/pc_fetch_unit_fetch_out_reg.sv
// One-entry valid/ready holding register between fetch and decode.
// Flush beats load, load beats drain (a same-edge reload keeps valid high).
module fetch_out_reg
   import pc_fetch_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  fetch_pkt_t load_pkt,
   input  logic       flush,
   input  logic       ready,
   output logic       valid,
   output fetch_pkt_t pkt
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         pkt   <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pkt   <= load_pkt;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register + req/ack instruction fetch FSM feeding decode through a
// one-entry output register; redirects flush, ack timeouts latch fetch_err.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 5
) (
   input  logic           clk,
   input  logic           reset,
   pc_fetch_unit_if.master bus
);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   fetch_state_e     state;
   logic [31:0]      pc;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      redir_pc;
   logic             out_valid, drain, load, flush, waiting, timeout_hit;
   fetch_pkt_t       out_pkt;

   assign redir_pc    = {bus.redirect_addr[31:2], 2'b00};
   assign drain       = out_valid && bus.inst_ready;
   assign waiting     = bus.imem_req && !bus.imem_ack;
   // a redirect clears the wait counter, so it pre-empts a timeout on the same edge
   assign timeout_hit = (TIMEOUT != 0) && waiting && !bus.redirect && (cnt == TO_LAST);
   assign load        = (state == S_FETCH) && bus.imem_ack && !bus.redirect;
   assign flush       = (bus.redirect && (state != S_ERROR)) || timeout_hit;

   assign bus.currentAddress = pc;
   assign bus.inst_valid     = out_valid;
   assign bus.instruction    = out_pkt.inst;
   assign bus.inst_pc        = out_pkt.pc;

   fetch_out_reg u_out (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_pkt ('{inst: bus.imem_rdata, pc: pc}),
      .flush    (flush),
      .ready    (bus.inst_ready),
      .valid    (out_valid),
      .pkt      (out_pkt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         pc            <= RESET_PC;
         cnt           <= '0;
         bus.imem_req  <= 1'b0;
         bus.imem_addr <= RESET_PC;
         bus.fetch_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.redirect) begin
                  pc            <= redir_pc;
                  state         <= S_FETCH;
                  bus.imem_req  <= 1'b1;
                  bus.imem_addr <= redir_pc;
               end else if (!out_valid || drain) begin
                  state         <= S_FETCH;
                  bus.imem_req  <= 1'b1;
                  bus.imem_addr <= pc;
               end
            end
            S_FETCH: begin
               if (bus.redirect) begin
                  pc  <= redir_pc;
                  cnt <= '0;
                  if (bus.imem_ack) bus.imem_addr <= redir_pc;
                  else              state         <= S_DISCARD;
               end else if (bus.imem_ack) begin
                  cnt <= '0;
                  pc  <= bus.newAddress;
                  // keep streaming only if decode frees the slot on this same edge
                  if (drain) begin
                     bus.imem_addr <= bus.newAddress;
                  end else begin
                     state        <= S_IDLE;
                     bus.imem_req <= 1'b0;
                  end
               end else if (timeout_hit) begin
                  state         <= S_ERROR;
                  bus.imem_req  <= 1'b0;
                  bus.fetch_err <= 1'b1;
                  cnt           <= cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DISCARD: begin
               if (bus.imem_ack) begin
                  cnt           <= '0;
                  state         <= S_FETCH;
                  bus.imem_addr <= bus.redirect ? redir_pc : pc;
                  if (bus.redirect) pc <= redir_pc;
               end else if (bus.redirect) begin
                  pc  <= redir_pc;
                  cnt <= '0;
               end else if (timeout_hit) begin
                  state         <= S_ERROR;
                  bus.imem_req  <= 1'b0;
                  bus.fetch_err <= 1'b1;
                  cnt           <= cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ERROR: ;
            default: state <= S_ERROR;
         endcase
      end
   end
endmodule
